// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one UART transmitter among N_REQ byte streams
// Grants one requester at a time, loads its byte with a one-cycle tx_start and waits for
// tx_done; frames without req_last keep the grant until their last byte.
// Optional: UART_TX_ARB_TIMEOUT_EN forces a release after TIMEOUT_CYCLES in WAIT_S/HOLD_S.
// Ports: clk, reset (async, active-high); req_valid/req_data/req_last in, req_ready out
// (requester side); grant, arb_busy, timeout_err status; tx_start/tx_data out and
// tx_busy/tx_done in (transmitter side).
module uart_tx_arbiter #(
  parameter int N_REQ = 4,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   grant,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  input  logic               tx_busy,
  input  logic               tx_done,
  output logic               arb_busy,
  output logic               timeout_err
);
  localparam int IW = N_REQ > 1 ? $clog2(N_REQ) : 1;
  typedef enum logic [1:0] {IDLE_S, LOAD_S, WAIT_S, HOLD_S} state_t;
  state_t r_state, w_next;
  logic [IW-1:0] r_last_grant, r_idx, w_pick, w_nidx;
  logic [N_REQ-1:0] r_grant;
  logic [7:0] r_tx_data;
  logic r_last_flag, w_load, w_release, w_timeout;
`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_cnt;
`else
  logic w_unused;
  assign w_unused = TIMEOUT_CYCLES[0];
`endif
  // scan from farthest to nearest so the nearest valid index after last_grant wins
  always_comb begin
    w_pick = '0;
    for (int k = N_REQ; k >= 1; k--)
      if (req_valid[IW'((int'(r_last_grant) + k) % N_REQ)]) w_pick = IW'((int'(r_last_grant) + k) % N_REQ);
  end
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_release = 1'b0;
    w_timeout = 1'b0;
    w_nidx = r_idx;
    case (r_state)
      IDLE_S: if (|req_valid && !tx_busy) begin
        w_load = 1'b1;
        w_nidx = w_pick;
        w_next = LOAD_S;
      end
      LOAD_S: w_next = WAIT_S;
      WAIT_S: if (tx_done) begin
        w_release = r_last_flag;
        w_next = r_last_flag ? IDLE_S : HOLD_S;
      end
      HOLD_S: if (req_valid[r_idx] && !tx_busy) begin
        w_load = 1'b1;
        w_next = LOAD_S;
      end
      default: w_next = IDLE_S;
    endcase
`ifdef UART_TX_ARB_TIMEOUT_EN
    // only fires while the state would otherwise stay put, i.e. no exit condition this cycle
    if ((r_state == WAIT_S || r_state == HOLD_S) && w_next == r_state && r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
      w_timeout = 1'b1;
      w_release = 1'b1;
      w_load = 1'b0;
      w_next = IDLE_S;
    end
`endif
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE_S;
      r_grant <= '0;
      r_idx <= '0;
      r_last_grant <= IW'(N_REQ - 1);
      r_tx_data <= 8'h00;
      r_last_flag <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_idx <= w_nidx;
        r_grant <= N_REQ'(1) << w_nidx;
        r_tx_data <= req_data[{w_nidx, 3'b000} +: 8];
        r_last_flag <= req_last[w_nidx];
      end
      if (w_release) begin
        r_last_grant <= r_idx;
        r_grant <= '0;
      end
    end
  end
`ifdef UART_TX_ARB_TIMEOUT_EN
  // any state change restarts the count, so it is zero on the first WAIT_S/HOLD_S cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_cnt <= '0;
    else r_cnt <= (w_next != r_state) ? '0 : r_cnt + 1'b1;
  end
`endif
  assign tx_start = r_state == LOAD_S;
  assign req_ready = tx_start ? r_grant : '0;
  assign grant = r_grant;
  assign tx_data = r_tx_data;
  assign arb_busy = r_state != IDLE_S;
  assign timeout_err = w_timeout;
endmodule
